// File: rtl/ssi_encoder_emulator.sv
// SSI encoder emulator: serves a latched position word over an externally clocked
// SSI link (idle-high clock, active-low select), MSB first, then the monoflop trailer.
// Optional build macro SSI_GRAY_CODE_EN: latch the word Gray-coded instead of binary.
module ssi_encoder_emulator #(
    parameter int unsigned DATA_WIDTH      = 21,
    parameter int unsigned MONOFLOP_CYCLES = 20
) (
    input  logic                  clk_1MHz,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] pos_in,
    input  logic                  pos_valid,
    input  logic                  ssi_clk,
    input  logic                  ssi_nsl,
    output logic                  ssi_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TmrW = $clog2(MONOFLOP_CYCLES);
    localparam logic [CntW-1:0] BitLast = CntW'(DATA_WIDTH);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(MONOFLOP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StMono} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic                  data_q, data_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;

    logic clk_s1, clk_s2, clk_s3;
    logic nsl_s1, nsl_s2;
    logic clk_rise, clk_fall, nsl_sync;
    logic [DATA_WIDTH-1:0] load_word;

    function automatic logic [DATA_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] bin);
`ifdef SSI_GRAY_CODE_EN
        return bin ^ (bin >> 1);
`else
        return bin;
`endif
    endfunction

    // Synchronize the asynchronous SSI pins; reset to their idle (high) levels.
    always_ff @(posedge clk_1MHz) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            nsl_s1 <= 1'b1;
            nsl_s2 <= 1'b1;
        end else begin
            clk_s1 <= ssi_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            nsl_s1 <= ssi_nsl;
            nsl_s2 <= nsl_s1;
        end
    end

    assign clk_rise = clk_s2 & ~clk_s3;
    assign clk_fall = ~clk_s2 & clk_s3;
    assign nsl_sync = nsl_s2;

    // A pos_valid in the latch cycle takes effect on that same frame.
    assign load_word = pos_valid ? pos_in : shadow_q;

    // Shadow register tracks the latest position regardless of frame state.
    always_ff @(posedge clk_1MHz) begin
        if (!resetn) begin
            shadow_q <= '0;
        end else if (pos_valid) begin
            shadow_q <= pos_in;
        end
    end

    // Frame state and datapath registers.
    always_ff @(posedge clk_1MHz) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic: frame latch, bit shifting, monoflop and timeout handling.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        data_d    = data_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            StIdle: begin
                data_d = 1'b1;
                if (clk_fall && !nsl_sync) begin
                    shreg_d   = encode(load_word);
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (nsl_sync) begin
                    state_d = StIdle;
                    data_d  = 1'b1;
                    abort_d = 1'b1;
                end else if (clk_fall && bit_cnt_q == BitLast) begin
                    data_d  = 1'b0;
                    timer_d = '0;
                    state_d = StMono;
                end else if (clk_rise) begin
                    data_d  = shreg_q[DATA_WIDTH-1];
                    shreg_d = shreg_q << 1;
                    timer_d = '0;
                    if (bit_cnt_q != BitLast) begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (clk_fall) begin
                    timer_d = '0;
                end else if (timer_q == TmrLast) begin
                    // Master went silent mid-word.
                    state_d = StIdle;
                    data_d  = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StMono: begin
                data_d = 1'b0;
                if (nsl_sync) begin
                    state_d = StIdle;
                    data_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (clk_rise || clk_fall) begin
                    // Extra clocks restart the monoflop and read zeros.
                    timer_d = '0;
                end else if (timer_q == TmrLast) begin
                    state_d = StIdle;
                    data_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                data_d  = 1'b1;
            end
        endcase
    end

    assign ssi_data    = data_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule
